// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-class character LCD sequencer:
// state encoding, init command ROM, pin bit positions and opcode helpers.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERON,
      ST_INIT_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT,
      ST_IDLE
   } state_t;

   localparam int INIT_LEN   = 5;
   localparam int INIT_IDX_W = 3;

   localparam int PIN_RS = 10;
   localparam int PIN_RW = 9;
   localparam int PIN_E  = 8;

   localparam logic [7:0] OP_CLEAR = 8'h01;
   localparam logic [7:0] OP_HOME  = 8'h02;

   // Function set 8-bit/2-line (twice), display on, clear, entry mode increment.
   function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
      logic [7:0] value;
      case (idx)
         3'd0:    value = 8'h38;
         3'd1:    value = 8'h38;
         3'd2:    value = 8'h0C;
         3'd3:    value = 8'h01;
         default: value = 8'h06;
      endcase
      return value;
   endfunction

   // Clear (0x01) and home (0x02/0x03) need the long execution time; bit 0 of home is don't-care.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == OP_CLEAR) || (data[7:1] == OP_HOME[7:1]));
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Shared down-counter pacing every sequencer state: load N-1 on entry,
// the state is done once the count reads zero.
module lcd_strobe_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   // The owner asserts load during reset, so no separate reset term is needed.
   always_ff @(posedge clk) begin
      if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_controller.sv
// Write-only character LCD sequencer: power-on wait, fixed init sequence,
// then host byte writes with all E-strobe and busy timing generated here.
module lcd_controller
   import lcd_pkg::*;
#(
   parameter int POWERON_CYCLES    = 750000,
   parameter int SETUP_CYCLES      = 4,
   parameter int PULSE_CYCLES      = 12,
   parameter int CMD_WAIT_CYCLES   = 2500,
   parameter int CLEAR_WAIT_CYCLES = 82000
) (
   input  logic        clk,
   input  logic        rst_in,
   input  logic        wrValid,
   input  logic        wrRS,
   input  logic [7:0]  wrData,
   output logic        wrReady,
   output logic        initDone,
   output logic [10:0] lcdPins
);

   localparam int MAX_CYCLES = max_of(max_of(POWERON_CYCLES, CLEAR_WAIT_CYCLES),
                                      max_of(max_of(SETUP_CYCLES, PULSE_CYCLES), CMD_WAIT_CYCLES));
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   state_t                  state_reg;
   state_t                  state_next;
   logic                    rs_reg;
   logic [7:0]              data_reg;
   logic                    init_done_reg;
   logic [INIT_IDX_W-1:0]   init_idx_reg;
   logic                    last_init;
   logic                    timer_load;
   logic [CNT_W-1:0]        timer_value;
   logic                    timer_zero;
   logic                    e_pin;
   logic                    ready;

   assign last_init = (init_idx_reg == INIT_IDX_W'(INIT_LEN - 1));

   lcd_strobe_timer #(
      .WIDTH(CNT_W)
   ) u_timer (
      .clk       (clk),
      .load      (timer_load),
      .load_value(timer_value),
      .zero      (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         state_reg <= ST_POWERON;
      end else begin
         state_reg <= state_next;
      end
   end

   // Latched byte and init progress; RS/Data only change on a ROM load or host transfer.
   always_ff @(posedge clk) begin
      if (!rst_in) begin
         rs_reg        <= 1'b0;
         data_reg      <= 8'h00;
         init_done_reg <= 1'b0;
         init_idx_reg  <= '0;
      end else begin
         if (state_reg == ST_INIT_LOAD) begin
            rs_reg   <= 1'b0;
            data_reg <= init_rom(init_idx_reg);
         end else if ((state_reg == ST_IDLE) && wrValid) begin
            rs_reg   <= wrRS;
            data_reg <= wrData;
         end
         if ((state_reg == ST_WAIT) && timer_zero && !init_done_reg) begin
            if (last_init) begin
               init_done_reg <= 1'b1;
            end else begin
               init_idx_reg <= init_idx_reg + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_POWERON:   if (timer_zero) state_next = ST_INIT_LOAD;
         ST_INIT_LOAD: state_next = ST_SETUP;
         ST_SETUP:     if (timer_zero) state_next = ST_PULSE;
         ST_PULSE:     if (timer_zero) state_next = ST_HOLD;
         ST_HOLD:      if (timer_zero) state_next = ST_WAIT;
         ST_WAIT: begin
            if (timer_zero) begin
               state_next = (init_done_reg || last_init) ? ST_IDLE : ST_INIT_LOAD;
            end
         end
         ST_IDLE:      if (wrValid) state_next = ST_SETUP;
         default:      state_next = ST_POWERON;
      endcase
   end

   // Every state change reloads the timer with the duration of the state being entered.
   always_comb begin
      timer_load  = !rst_in || (state_next != state_reg);
      timer_value = '0;
      if (!rst_in) begin
         timer_value = CNT_W'(POWERON_CYCLES - 1);
      end else begin
         case (state_next)
            ST_POWERON: timer_value = CNT_W'(POWERON_CYCLES - 1);
            ST_SETUP:   timer_value = CNT_W'(SETUP_CYCLES - 1);
            ST_PULSE:   timer_value = CNT_W'(PULSE_CYCLES - 1);
            ST_HOLD:    timer_value = CNT_W'(SETUP_CYCLES - 1);
            ST_WAIT: begin
               if (is_long_cmd(rs_reg, data_reg)) begin
                  timer_value = CNT_W'(CLEAR_WAIT_CYCLES - 1);
               end else begin
                  timer_value = CNT_W'(CMD_WAIT_CYCLES - 1);
               end
            end
            default:    timer_value = '0;
         endcase
      end
   end

   always_comb begin
      e_pin = (state_reg == ST_PULSE);
      ready = (state_reg == ST_IDLE);
   end

   always_comb begin
      lcdPins         = '0;
      lcdPins[PIN_RS] = rs_reg;
      lcdPins[PIN_RW] = 1'b0;
      lcdPins[PIN_E]  = e_pin;
      lcdPins[7:0]    = data_reg;
   end

   assign wrReady  = ready;
   assign initDone = init_done_reg;

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: expected E-pulse bytes are queued by the
// stimulus and checked by an independent pin monitor; timing checked inline.
`timescale 1ns/1ps
module tb_lcd_controller;

   localparam int PON = 20;
   localparam int S   = 2;
   localparam int P   = 3;
   localparam int CW  = 10;
   localparam int CLW = 40;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        wrValid = 1'b0;
   logic        wrRS = 1'b0;
   logic [7:0]  wrData = 8'h00;
   logic        wrReady;
   logic        initDone;
   logic [10:0] lcdPins;

   lcd_controller #(
      .POWERON_CYCLES   (PON),
      .SETUP_CYCLES     (S),
      .PULSE_CYCLES     (P),
      .CMD_WAIT_CYCLES  (CW),
      .CLEAR_WAIT_CYCLES(CLW)
   ) dut (
      .clk     (clk),
      .rst_in  (rst_in),
      .wrValid (wrValid),
      .wrRS    (wrRS),
      .wrData  (wrData),
      .wrReady (wrReady),
      .initDone(initDone),
      .lcdPins (lcdPins)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_rise = -1;
   int   width = 0;
   bit   abort_pulse = 0;
   logic e_prev = 1'b0;
   exp_t mon_x;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Pin monitor: each E rise pops one expected byte; each completed pulse is width-checked.
   always @(negedge clk) begin
      if (lcdPins[8] && !e_prev) begin
         last_rise = cyc;
         width = 0;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_pulse: got pins 0x%0h, expected no pulse (cycle %0d)", lcdPins, cyc);
         end else begin
            mon_x = exp_q.pop_front();
            check("pulse_rs_rw_data", {lcdPins[10:9], lcdPins[7:0]}, {mon_x.rs, 1'b0, mon_x.data});
            $display("pulse at cycle %0d: rs=%0b data=0x%02h", cyc, lcdPins[10], lcdPins[7:0]);
         end
      end
      if (lcdPins[8]) width++;
      if (!lcdPins[8] && e_prev) begin
         if (abort_pulse) abort_pulse = 0;
         else check("pulse_width", width, P);
      end
      e_prev = lcdPins[8];
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!wrReady && n < 300) begin
         tick();
         n++;
      end
      if (!wrReady) begin
         checks++;
         fails++;
         $display("FAIL ready_timeout: got wrReady=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic push_init();
      exp_t x;
      logic [7:0] rom [5];
      rom = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      for (int i = 0; i < 5; i++) begin
         x.rs = 1'b0;
         x.data = rom[i];
         exp_q.push_back(x);
      end
   endtask

   // Single host write from a negedge with the controller idle; returns accept-to-ready latency.
   task automatic host_write(input logic rs, input logic [7:0] data, output int lat);
      exp_t x;
      int acc;
      check("ready_before_write", wrReady, 1);
      wrRS = rs;
      wrData = data;
      wrValid = 1'b1;
      x.rs = rs;
      x.data = data;
      exp_q.push_back(x);
      tick();
      acc = cyc;
      wrValid = 1'b0;
      check("ready_low_after_accept", wrReady, 0);
      wait_ready(lat);
      check("e_rise_offset", last_rise - acc, S);
      $display("write rs=%0b data=0x%02h accepted at cycle %0d, ready after %0d", rs, data, acc, lat);
   endtask

   // Runs 140 cycles from reset release; checks first E rise, initDone timing and no early ready.
   task automatic run_init(input string tag);
      int first_rise;
      int early;
      first_rise = -1;
      early = 0;
      for (int i = 1; i <= 140; i++) begin
         tick();
         if (first_rise < 0 && lcdPins[8]) first_rise = i;
         if (i < 140 && wrReady) early++;
         if (i == 139) check({tag, "_initdone_139"}, initDone, 0);
      end
      check({tag, "_first_e_rise"}, first_rise, PON + 1 + S);
      check({tag, "_initdone_140"}, initDone, 1);
      check({tag, "_ready_140"}, wrReady, 1);
      check({tag, "_no_early_ready"}, early, 0);
      check({tag, "_init_queue_drained"}, exp_q.size(), 0);
      $display("%s init finished at cycle %0d", tag, cyc);
   endtask

   initial begin
      int lat;
      int n;
      int acc[3];
      logic       b_rs [3];
      logic [7:0] b_dat [3];
      exp_t x;

      // Reset state
      repeat (3) tick();
      check("reset_pins", lcdPins, 0);
      check("reset_ready", wrReady, 0);
      check("reset_initdone", initDone, 0);

      // Power-on + init with no host activity
      push_init();
      rst_in = 1'b1;
      run_init("boot");

      // Single host writes
      host_write(1'b1, 8'h41, lat);
      check("lat_data_41", lat, S + P + S + CW);
      tick();
      host_write(1'b0, 8'h01, lat);
      check("lat_clear_cmd", lat, S + P + S + CLW);
      tick();
      host_write(1'b1, 8'h01, lat);
      check("lat_data_01", lat, S + P + S + CW);
      tick();

      // Back-to-back writes with wrValid held high
      b_rs  = '{1'b1, 1'b1, 1'b0};
      b_dat = '{8'h48, 8'h49, 8'h80};
      wrValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wrRS = b_rs[k];
         wrData = b_dat[k];
         wait_ready(n);
         x.rs = b_rs[k];
         x.data = b_dat[k];
         exp_q.push_back(x);
         tick();
         acc[k] = cyc;
         $display("b2b write %0d rs=%0b data=0x%02h accepted at cycle %0d", k, b_rs[k], b_dat[k], acc[k]);
      end
      wrValid = 1'b0;
      check("b2b_interval_1", acc[1] - acc[0], S + P + S + CW + 1);
      check("b2b_interval_2", acc[2] - acc[1], S + P + S + CW + 1);
      wait_ready(lat);
      check("b2b_last_lat", lat, S + P + S + CW);
      tick();

      // Reset asserted for one cycle in the middle of an E pulse
      wrRS = 1'b1;
      wrData = 8'h55;
      wrValid = 1'b1;
      x.rs = 1'b1;
      x.data = 8'h55;
      exp_q.push_back(x);
      tick();
      wrValid = 1'b0;
      n = 0;
      while (!lcdPins[8] && n < 50) begin
         tick();
         n++;
      end
      check("abort_e_seen", lcdPins[8], 1);
      tick();
      abort_pulse = 1;
      rst_in = 1'b0;
      tick();
      check("abort_pins", lcdPins, 0);
      check("abort_initdone", initDone, 0);
      check("abort_ready", wrReady, 0);
      check("abort_queue_empty", exp_q.size(), 0);
      exp_q.delete();
      $display("reset applied mid-pulse at cycle %0d", cyc);

      // Replay with a host request pending throughout init
      push_init();
      rst_in = 1'b1;
      wrRS = 1'b1;
      wrData = 8'h5A;
      wrValid = 1'b1;
      run_init("replay");
      x.rs = 1'b1;
      x.data = 8'h5A;
      exp_q.push_back(x);
      tick();
      wrValid = 1'b0;
      wait_ready(lat);
      check("replay_pending_lat", lat, S + P + S + CW);
      repeat (3) tick();
      check("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
